// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: reset vector, bubble encoding
// and the fetch controller state type.
package mips_pkg;

    localparam logic [31:0] MIPS_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] MIPS_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry buffer for an instruction that arrived while decode was stalled,
// together with its PC+4 and a valid bit.
module fetch_skid_buffer
    import mips_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(MIPS_NOP_INSTR)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   clear,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic [ADDR_WIDTH-1:0]  pcp4_in,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  pcp4_out,
    output logic                   valid_out
);

    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  pcp4_q, pcp4_d;
    logic                   valid_q, valid_d;

    // load wins over clear; the controller never asserts both
    always_comb begin
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (load) begin
            instr_d = instr_in;
            pcp4_d  = pcp4_in;
            valid_d = 1'b1;
        end else if (clear) begin
            instr_d = NOP_INSTR;
            pcp4_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_out = instr_q;
    assign pcp4_out  = pcp4_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: owns the PC, runs the instruction-memory handshake and
// feeds the F/D register, inserting bubbles for latency, stalls and redirects.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = ADDR_WIDTH'(MIPS_RESET_PC),
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(MIPS_NOP_INSTR)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   StallF,
    input  logic                   Redirect,
    input  logic [ADDR_WIDTH-1:0]  RedirectPC,
    output logic                   IMemReq,
    output logic [ADDR_WIDTH-1:0]  IMemAddr,
    input  logic                   IMemAck,
    input  logic [INSTR_WIDTH-1:0] IMemRData,
    output logic [INSTR_WIDTH-1:0] InstrF,
    output logic [ADDR_WIDTH-1:0]  PCPlus4F,
    output logic                   InstrValidF
);

    fetch_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [ADDR_WIDTH-1:0]   pc_plus4;
    logic [ADDR_WIDTH-1:0]   redirect_pc;

    logic                    buf_load, buf_clear, buf_valid;
    logic [INSTR_WIDTH-1:0]  buf_instr;
    logic [ADDR_WIDTH-1:0]   buf_pcp4;

    logic                    req;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [INSTR_WIDTH-1:0]  instr;
    logic [ADDR_WIDTH-1:0]   pcp4;
    logic                    vld;

    assign pc_plus4    = pc_q + ADDR_WIDTH'(4);
    assign redirect_pc = {RedirectPC[ADDR_WIDTH-1:2], 2'b00};

    fetch_skid_buffer #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH),
        .NOP_INSTR   (NOP_INSTR)
    ) u_skid (
        .clk       (CLK),
        .rst_n     (RST),
        .load      (buf_load),
        .clear     (buf_clear),
        .instr_in  (IMemRData),
        .pcp4_in   (pc_plus4),
        .instr_out (buf_instr),
        .pcp4_out  (buf_pcp4),
        .valid_out (buf_valid)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        req        = 1'b0;
        addr       = pc_q;
        instr      = NOP_INSTR;
        pcp4       = '0;
        vld        = 1'b0;

        unique case (state_q)
            FETCH: begin
                req = 1'b1;
                if (Redirect) begin
                    pc_d       = redirect_pc;
                    req_addr_d = pc_q;
                    state_d    = IMemAck ? FETCH : DROP;
                end else if (IMemAck) begin
                    if (StallF) begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        instr = IMemRData;
                        pcp4  = pc_plus4;
                        vld   = 1'b1;
                        pc_d  = pc_plus4;
                    end
                end
            end
            HOLD: begin
                if (Redirect) begin
                    pc_d      = redirect_pc;
                    buf_clear = 1'b1;
                    state_d   = FETCH;
                end else if (!StallF) begin
                    instr     = buf_instr;
                    pcp4      = buf_pcp4;
                    vld       = buf_valid;
                    pc_d      = pc_plus4;
                    buf_clear = 1'b1;
                    state_d   = FETCH;
                end
            end
            DROP: begin
                // keep presenting the abandoned address until its ack retires it
                req  = 1'b1;
                addr = req_addr_q;
                if (Redirect) begin
                    pc_d = redirect_pc;
                end
                // a redirect coinciding with the stale ack still consumes it,
                // otherwise we would wait for an ack that never comes
                if (IMemAck) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // reset must silence the port and outputs without waiting for a clock
        if (!RST) begin
            req   = 1'b0;
            instr = NOP_INSTR;
            pcp4  = '0;
            vld   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign IMemReq     = req;
    assign IMemAddr    = addr;
    assign InstrF      = instr;
    assign PCPlus4F    = pcp4;
    assign InstrValidF = vld;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and random checks of the fetch unit against an in-order
// "next instruction address" model and a synthetic instruction memory.
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        StallF, Redirect, IMemAck;
    logic [31:0] RedirectPC, IMemRData;
    logic        IMemReq, InstrValidF;
    logic [31:0] IMemAddr, InstrF, PCPlus4F;

    always #5 CLK = ~CLK;

    instruction_fetch_unit dut (
        .CLK         (CLK),
        .RST         (RST),
        .StallF      (StallF),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC),
        .IMemReq     (IMemReq),
        .IMemAddr    (IMemAddr),
        .IMemAck     (IMemAck),
        .IMemRData   (IMemRData),
        .InstrF      (InstrF),
        .PCPlus4F    (PCPlus4F),
        .InstrValidF (InstrValidF)
    );

    int          checks    = 0;
    int          failures  = 0;
    int          delivered = 0;
    int          age       = 0;
    logic [31:0] exp_pc    = 32'h0;
    logic        prev_req  = 1'b0;
    logic        prev_ack  = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    // program image: unique, never-zero word per aligned address
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2008_0005 : (~a ^ 32'h1234_0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock: drive at negedge, check combinational outputs 1ns later,
    // then advance the model to what should hold after the next posedge
    task automatic drive(input logic stall, input logic redir,
                         input logic [31:0] tgt, input logic ack);
        @(negedge CLK);
        StallF     = stall;
        Redirect   = redir;
        RedirectPC = tgt;
        IMemAck    = ack && IMemReq && (age >= 1);
        IMemRData  = IMemAck ? mem(IMemAddr) : 32'hDEAD_BEEF;
        #1;
        if (prev_req && !prev_ack) begin
            chk("req_held", {31'b0, IMemReq}, 32'h1);
            chk("addr_stable", IMemAddr, prev_addr);
        end
        if (IMemReq) chk("addr_align", {30'b0, IMemAddr[1:0]}, 32'h0);
        if (!InstrValidF) chk("bubble_nop", InstrF, 32'h0);
        if (redir) begin
            chk("redir_kills", {31'b0, InstrValidF}, 32'h0);
            exp_pc = {tgt[31:2], 2'b00};
        end else if (InstrValidF) begin
            chk("valid_under_stall", {31'b0, stall}, 32'h0);
            chk("instr", InstrF, mem(exp_pc));
            chk("pcplus4", PCPlus4F, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        age       = (IMemReq && !IMemAck) ? age + 1 : 0;
        prev_req  = IMemReq;
        prev_ack  = IMemAck;
        prev_addr = IMemAddr;
    endtask

    task automatic do_reset(input int hold);
        @(negedge CLK);
        #2;
        RST      = 1'b0;
        IMemAck  = 1'b0;
        StallF   = 1'b0;
        Redirect = 1'b0;
        #1;
        chk("rst_req", {31'b0, IMemReq}, 32'h0);
        chk("rst_instr", InstrF, 32'h0);
        chk("rst_pcp4", PCPlus4F, 32'h0);
        chk("rst_valid", {31'b0, InstrValidF}, 32'h0);
        repeat (hold) @(negedge CLK);
        RST      = 1'b1;
        exp_pc   = 32'h0;
        age      = 0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
    endtask

    initial begin
        int d0;
        int n;
        RST = 1'b1; StallF = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;
        IMemAck = 1'b0; IMemRData = 32'h0;

        // reset, first fetch from address 0
        do_reset(2);
        drive(0, 0, 32'h0, 0);
        chk("first_req", {31'b0, IMemReq}, 32'h1);
        chk("first_addr", IMemAddr, 32'h0);
        drive(0, 0, 32'h0, 1);
        chk("t1_valid", {31'b0, InstrValidF}, 32'h1);
        chk("t1_instr", InstrF, 32'h2008_0005);
        chk("t1_pcp4", PCPlus4F, 32'h4);
        drive(0, 0, 32'h0, 0);
        chk("t1_next_addr", IMemAddr, 32'h4);

        // ack under stall, three held cycles, then release
        drive(1, 0, 32'h0, 1);
        chk("stall_ack_bubble", {31'b0, InstrValidF}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h0, 0);
            chk("hold_req", {31'b0, IMemReq}, 32'h0);
            chk("hold_valid", {31'b0, InstrValidF}, 32'h0);
        end
        drive(0, 0, 32'h0, 0);
        chk("release_valid", {31'b0, InstrValidF}, 32'h1);
        chk("release_instr", InstrF, mem(32'h4));
        drive(0, 0, 32'h0, 0);
        chk("after_hold_addr", IMemAddr, 32'h8);

        // redirect while request to 8 is outstanding
        drive(0, 1, 32'h0000_0103, 0);
        drive(0, 0, 32'h0, 0);
        chk("drop_addr", IMemAddr, 32'h8);
        drive(0, 0, 32'h0, 1);
        chk("stale_dropped", {31'b0, InstrValidF}, 32'h0);
        drive(0, 0, 32'h0, 0);
        chk("post_drop_addr", IMemAddr, 32'h100);

        // redirect and ack in the same cycle
        drive(0, 1, 32'h0000_0200, 1);
        chk("redir_ack_valid", {31'b0, InstrValidF}, 32'h0);
        drive(0, 0, 32'h0, 0);
        chk("redir_ack_addr", IMemAddr, 32'h200);

        // PC wrap at the top of the address space
        drive(0, 1, 32'hFFFF_FFFC, 1);
        drive(0, 0, 32'h0, 0);
        chk("wrap_addr", IMemAddr, 32'hFFFF_FFFC);
        drive(0, 0, 32'h0, 1);
        chk("wrap_valid", {31'b0, InstrValidF}, 32'h1);
        chk("wrap_pcp4", PCPlus4F, 32'h0);
        drive(0, 0, 32'h0, 0);
        chk("wrap_next_addr", IMemAddr, 32'h0);

        // reset while in HOLD, then while a request is outstanding
        drive(1, 0, 32'h0, 1);
        drive(1, 0, 32'h0, 0);
        chk("hold_before_rst", {31'b0, IMemReq}, 32'h0);
        do_reset(2);
        drive(0, 0, 32'h0, 0);
        chk("post_rst_req", {31'b0, IMemReq}, 32'h1);
        chk("post_rst_addr", IMemAddr, 32'h0);
        drive(0, 0, 32'h0, 0);
        do_reset(1);
        drive(0, 0, 32'h0, 0);
        chk("post_rst2_addr", IMemAddr, 32'h0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) == 0, ($urandom % 16) == 0, $urandom, $urandom % 2);
        end

        // forward progress once stalls and redirects stop
        d0 = delivered;
        n  = 0;
        while (delivered == d0 && n < 20) begin
            drive(0, 0, 32'h0, 1);
            n++;
        end
        chk("liveness", {31'b0, delivered > d0}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
